// File: rtl/fnd_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Contents: scan state enum, default blank segment value, and active-low
// segment patterns (bit order dp,g,f,e,d,c,b,a) for digits 0-9 and a dash.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } scan_state_e;

    localparam logic [7:0] SEG_BLANK_DEF = 8'hFF;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;

endpackage

// File: rtl/fnd_slot_timer.sv
// Digit slot timer: counts 0..SCAN_DIV-1 while run_i is high, held at 0 otherwise.
// Ports:
//   clk_i            clock, posedge
//   rst_ni           synchronous active-low reset
//   run_i            1 = count, 0 = clear and hold at 0
//   blank_start_c_o  combinational strobe on the last active cycle of a slot
//   slot_end_c_o     combinational strobe on the last cycle of a slot
module fnd_slot_timer #(
    parameter int unsigned SCAN_DIV  = 5000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic blank_start_c_o,
    output logic slot_end_c_o
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q;

    assign blank_start_c_o = (cnt_q == CNT_W'(SCAN_DIV - BLANK_CYC - 1));
    assign slot_end_c_o    = (cnt_q == CNT_W'(SCAN_DIV - 1));

    // Slot counter; wraps at the end of each slot.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !run_i) begin
            cnt_q <= '0;
        end else if (slot_end_c_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller with per-slot blanking, frame-latched
// shadow buffer, digit mask and enable.
// Ports:
//   clk_wiz      clock, posedge
//   rst          synchronous active-low reset
//   en           1 = scanning, 0 = dark and counters held at 0
//   seg_in       digit i pattern at [i*SEG_W +: SEG_W], latched at frame start
//   dig_mask     1 = digit i shown, latched at frame start
//   seg_out      registered segment bus
//   dig_out      registered one-hot digit enable (polarity per DIG_ACT_HIGH)
//   frame_start  registered 1-cycle pulse when the digit 0 slot begins
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned      N_DIG        = 4,
    parameter int unsigned      SEG_W        = 8,
    parameter int unsigned      SCAN_DIV     = 5000,
    parameter int unsigned      BLANK_CYC    = 16,
    parameter bit               DIG_ACT_HIGH = 1'b1,
    parameter logic [SEG_W-1:0] SEG_BLANK    = SEG_W'(SEG_BLANK_DEF)
) (
    input  logic                   clk_wiz,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_DIG*SEG_W-1:0] seg_in,
    input  logic [N_DIG-1:0]       dig_mask,
    output logic [SEG_W-1:0]       seg_out,
    output logic [N_DIG-1:0]       dig_out,
    output logic                   frame_start
);

    localparam int unsigned IDX_W = $clog2(N_DIG);
    localparam logic [N_DIG-1:0] DIG_OFF = DIG_ACT_HIGH ? {N_DIG{1'b0}} : {N_DIG{1'b1}};

    scan_state_e      state_q;
    logic [IDX_W-1:0] idx_q;
    logic [SEG_W-1:0] shadow_q [N_DIG];
    logic [N_DIG-1:0] mask_q;

    logic             blank_start;
    logic             slot_end;
    logic             wrap;
    logic             advance;
    logic [IDX_W-1:0] idx_d;
    logic [SEG_W-1:0] pat_d;
    logic             on_d;

    // Digit enable pattern for one slot, honouring polarity and mask.
    function automatic logic [N_DIG-1:0] dig_sel(input logic [IDX_W-1:0] idx, input logic on);
        logic [N_DIG-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        if (!on) begin
            return DIG_OFF;
        end
        return DIG_ACT_HIGH ? oh : ~oh;
    endfunction

    fnd_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .clk_i           (clk_wiz),
        .rst_ni          (rst),
        .run_i           (en && (state_q != ST_IDLE)),
        .blank_start_c_o (blank_start),
        .slot_end_c_o    (slot_end)
    );

    // Next-slot selection. A fresh frame (from IDLE or after the last digit)
    // takes digit 0 straight from the inputs, as they are latched on that edge.
    always_comb begin
        wrap    = (state_q == ST_IDLE) || (idx_q == IDX_W'(N_DIG - 1));
        idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
        advance = (state_q == ST_IDLE)
               || ((state_q == ST_ACTIVE) && blank_start && (BLANK_CYC == 0))
               || ((state_q == ST_BLANK) && slot_end);
        if (wrap) begin
            pat_d = seg_in[SEG_W-1:0];
            on_d  = dig_mask[0];
        end else begin
            pat_d = shadow_q[idx_d];
            on_d  = mask_q[idx_d];
        end
    end

    // Scan FSM, shadow buffer and registered outputs.
    always_ff @(posedge clk_wiz) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            for (int i = 0; i < N_DIG; i++) begin
                shadow_q[i] <= SEG_BLANK;
            end
            seg_out     <= SEG_BLANK;
            dig_out     <= DIG_OFF;
            frame_start <= 1'b0;
        end else if (!en) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            seg_out     <= SEG_BLANK;
            dig_out     <= DIG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (advance) begin
                state_q     <= ST_ACTIVE;
                idx_q       <= idx_d;
                frame_start <= wrap;
                if (wrap) begin
                    mask_q <= dig_mask;
                    for (int i = 0; i < N_DIG; i++) begin
                        shadow_q[i] <= seg_in[i*SEG_W +: SEG_W];
                    end
                end
                seg_out <= on_d ? pat_d : SEG_BLANK;
                dig_out <= dig_sel(idx_d, on_d);
            end else if ((state_q == ST_ACTIVE) && blank_start) begin
                state_q <= ST_BLANK;
                seg_out <= SEG_BLANK;
                dig_out <= DIG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed scenarios then random stimulus, all
// checked each cycle against a time-based model of the scan frame.
module tb_fnd_scan_ctrl;

    localparam int N_DIG     = 4;
    localparam int SEG_W     = 8;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = N_DIG * SCAN_DIV;
    localparam int ACT_CYC   = SCAN_DIV - BLANK_CYC;

    logic                   clk_wiz = 1'b0;
    logic                   rst;
    logic                   en;
    logic [N_DIG*SEG_W-1:0] seg_in;
    logic [N_DIG-1:0]       dig_mask;
    logic [SEG_W-1:0]       seg_out;
    logic [N_DIG-1:0]       dig_out;
    logic                   frame_start;

    always #5 clk_wiz = ~clk_wiz;

    fnd_scan_ctrl #(
        .N_DIG        (N_DIG),
        .SEG_W        (SEG_W),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .DIG_ACT_HIGH (1'b1),
        .SEG_BLANK    (8'hFF)
    ) dut (
        .clk_wiz     (clk_wiz),
        .rst         (rst),
        .en          (en),
        .seg_in      (seg_in),
        .dig_mask    (dig_mask),
        .seg_out     (seg_out),
        .dig_out     (dig_out),
        .frame_start (frame_start)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: scanning flag, cycles since scan start, frame-latched copies.
    bit         m_run = 1'b0;
    int         m_t   = 0;
    logic [7:0] m_shadow [N_DIG];
    logic [3:0] m_mask = 4'h0;
    int         cur_slot = 0;
    int         cur_off  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic latch_inputs();
        for (int i = 0; i < N_DIG; i++) m_shadow[i] = seg_in[i*SEG_W +: SEG_W];
        m_mask = dig_mask;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int         pos;
        bit         lit;
        logic [7:0] e_seg;
        logic [3:0] e_dig;
        @(posedge clk_wiz);
        cyc++;
        if (!rst) begin
            m_run = 1'b0;
            m_t   = 0;
            for (int i = 0; i < N_DIG; i++) m_shadow[i] = 8'hFF;
            m_mask = 4'h0;
        end else if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
            latch_inputs();
        end else begin
            m_t++;
            if (m_t % FRAME == 0) latch_inputs();
        end
        #1;
        pos      = m_t % FRAME;
        cur_slot = pos / SCAN_DIV;
        cur_off  = pos % SCAN_DIV;
        lit      = m_run && (cur_off < ACT_CYC) && m_mask[cur_slot];
        e_seg    = lit ? m_shadow[cur_slot] : 8'hFF;
        e_dig    = lit ? 4'(1 << cur_slot) : 4'b0000;
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("dig_out", 32'(dig_out), 32'(e_dig));
        check("frame_start", 32'(frame_start), 32'(m_run && (pos == 0)));
    endtask

    // Step until the model is in the given slot's active or blank phase.
    task automatic wait_phase(input int slot, input bit blank);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 3 * FRAME && !found; k++) begin
            if (m_run && (cur_slot == slot) && ((cur_off >= ACT_CYC) == blank)) found = 1'b1;
            else step();
        end
        check("wait_phase", 32'(found), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < N_DIG; i++) m_shadow[i] = 8'hFF;
        rst      = 1'b0;
        en       = 1'b1;
        seg_in   = {8'hA4, 8'hB0, 8'hF9, 8'hC0};
        dig_mask = 4'hF;

        // Reset held with en=1
        repeat (3) step();

        // Normal scan, then a mid-frame change of digit 0
        rst = 1'b1;
        repeat (10) step();
        seg_in[7:0] = 8'h99;
        repeat (70) step();

        // Digit 2 masked
        dig_mask = 4'b1011;
        repeat (70) step();
        dig_mask = 4'hF;

        // Enable drop during digit 1 active
        wait_phase(1, 1'b0);
        en = 1'b0;
        repeat (2) step();
        en = 1'b1;
        repeat (40) step();

        // Reset during digit 3 blanking
        wait_phase(3, 1'b1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (40) step();

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 19) == 0) seg_in = $urandom;
            if ($urandom_range(0, 29) == 0) dig_mask = 4'($urandom);
            en  = ($urandom_range(0, 39) != 0);
            rst = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
